// File: rtl/alu_console_pkg.sv
// Shared types, opcodes and glyph decoder for the ALU console.
// Button indices match the board's btn[4:0] wiring.
package alu_console_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    VX    = 2'd0,
    VY    = 2'd1,
    VZ    = 2'd2,
    VNONE = 2'd3
  } view_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  localparam int BTN_UP     = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_CENTER = 4;
  localparam int NBTN       = 5;

  // Active-low segments, a in bit 0 through g in bit 6
  function automatic logic [6:0] hex_to_sseg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_console_btn_debounce.sv
// Per-button debouncer: level flips after DEB_CYCLES stable samples,
// press_o pulses for one cycle on each accepted rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (raw_i == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      level_d = raw_i;
      press_d = raw_i;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/alu_console.sv
// Operand-entry console: debounced buttons load X/Y, step the op,
// run a one-cycle registered execute, and scan a hex view to 7-seg.
import alu_console_pkg::*;

module alu_console #(
  parameter int W            = 16,
  parameter int NDIG         = 8,
  parameter int DEB_CYCLES   = 500000,
  parameter int REFRESH_BITS = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     sw,
  input  logic [4:0]      btn,
  output logic [NDIG-1:0] an,
  output logic [7:0]      sseg,
  output logic [7:0]      led
);

  localparam int SHW  = $clog2(W);
  localparam int NNIB = W / 4;
  localparam int DW   = $clog2(NDIG);

  logic [NBTN-1:0] prs;
  logic [NBTN-1:0] lvl_unused;

  for (genvar i = 0; i < NBTN; i++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (btn[i]),
      .level_o(lvl_unused[i]),
      .press_o(prs[i])
    );
  end

  state_t  state_q, state_d;
  alu_op_t op_q, op_d;
  view_t   view_q, view_d;
  logic [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic eq_q, eq_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [REFRESH_BITS-1:0] scan_q;

  logic [W-1:0] sw_w;
  assign sw_w = W'(sw);

  // ALU on the registered operands
  logic [W-1:0] sum, dif, alu_z;
  logic         alu_v;
  logic [SHW-1:0] sh;

  assign sum = x_q + y_q;
  assign dif = x_q - y_q;
  assign sh  = y_q[SHW-1:0];

  always_comb begin
    alu_z = '0;
    alu_v = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_z = sum;
        alu_v = (x_q[W-1] == y_q[W-1]) && (sum[W-1] != x_q[W-1]);
      end
      OP_SUB: begin
        alu_z = dif;
        alu_v = (x_q[W-1] != y_q[W-1]) && (dif[W-1] != x_q[W-1]);
      end
      OP_AND: alu_z = x_q & y_q;
      OP_OR:  alu_z = x_q | y_q;
      OP_XOR: alu_z = x_q ^ y_q;
      OP_SLT: alu_z = W'($signed(x_q) < $signed(y_q));
      OP_SLL: alu_z = x_q << sh;
      OP_SRL: alu_z = x_q >> sh;
      default: alu_z = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EXEC: state_d = S_SHOW;
      default: begin
        if (prs[BTN_CENTER])
          state_d = S_EXEC;
        else if (prs[BTN_UP] || prs[BTN_DOWN])
          state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    op_d   = op_q;
    view_d = view_q;
    eq_d   = eq_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    if (state_q == S_EXEC) begin
      z_d    = alu_z;
      eq_d   = (x_q == y_q);
      zero_d = (alu_z == '0);
      ovf_d  = alu_v;
      view_d = VZ;
    end else begin
      // Only the highest-priority press acts; centre owns the cycle
      priority case (1'b1)
        prs[BTN_CENTER]: ;
        prs[BTN_UP]: begin
          x_d    = sw_w;
          view_d = VX;
        end
        prs[BTN_DOWN]: begin
          y_d    = sw_w;
          view_d = VY;
        end
        prs[BTN_RIGHT]: op_d = alu_op_t'(op_q + 3'd1);
        prs[BTN_LEFT]:  op_d = alu_op_t'(op_q - 3'd1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      op_q   <= OP_ADD;
      view_q <= VX;
      eq_q   <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      scan_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      op_q   <= op_d;
      view_q <= view_d;
      eq_q   <= eq_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      scan_q <= scan_q + 1'b1;
    end
  end

  logic [DW-1:0] dig;
  logic [W-1:0]  vval, vsh;
  logic          vblank;

  assign dig = DW'(int'(scan_q[REFRESH_BITS-1 -: DW]) % NDIG);

  always_comb begin
    vval   = '0;
    vblank = 1'b0;
    unique case (view_q)
      VX: vval = x_q;
      VY: vval = y_q;
      VZ: vval = z_q;
      default: vblank = 1'b1;
    endcase
    vsh  = vval >> {dig, 2'b00};
    an   = ~(NDIG'(1) << dig);
    sseg = {1'b1, hex_to_sseg(vsh[3:0])};
    if (vblank || int'(dig) >= NNIB)
      sseg = 8'hFF;
    led = {view_q, ovf_q, zero_q, eq_q, op_q};
  end

endmodule

// File: tb/tb_alu_console.sv
// Randomised bench for alu_console against an arithmetic reference model;
// register contents are recovered by decoding a full display scan.
module tb_alu_console;

  localparam int W    = 16;
  localparam int NDIG = 8;
  localparam int DEB  = 4;
  localparam int RB   = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic [7:0]  an, sseg, led;

  always #5 clk = ~clk;

  alu_console #(
    .W(W), .NDIG(NDIG), .DEB_CYCLES(DEB), .REFRESH_BITS(RB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn),
    .an(an), .sseg(sseg), .led(led)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [6:0] gly [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int  mx, my, mz, mop, mview;
  bit  meq, mzero, movf;

  function automatic int sgn(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic void model_reset();
    mx = 0; my = 0; mz = 0; mop = 0; mview = 0;
    meq = 0; mzero = 0; movf = 0;
  endfunction

  function automatic void model_exec();
    int s;
    movf = 0;
    case (mop)
      0: begin
        s = sgn(mx) + sgn(my);
        mz = (mx + my) % 65536;
        movf = (s > 32767) || (s < -32768);
      end
      1: begin
        s = sgn(mx) - sgn(my);
        mz = (mx - my + 65536) % 65536;
        movf = (s > 32767) || (s < -32768);
      end
      2: mz = mx & my;
      3: mz = mx | my;
      4: mz = mx ^ my;
      5: mz = (sgn(mx) < sgn(my)) ? 1 : 0;
      6: mz = (mx << (my % 16)) % 65536;
      default: mz = mx >> (my % 16);
    endcase
    meq = (mx == my);
    mzero = (mz == 0);
    mview = 2;
  endfunction

  // Highest-priority press in the mask decides the model action
  function automatic void model_press(input int mask, input int v);
    if (mask[4]) model_exec();
    else if (mask[0]) begin mx = v; mview = 0; end
    else if (mask[2]) begin my = v; mview = 1; end
    else if (mask[1]) mop = (mop + 1) % 8;
    else if (mask[3]) mop = (mop + 7) % 8;
  endfunction

  task automatic press(input int mask, input int v);
    @(negedge clk);
    sw = 16'(v);
    btn = 5'(mask);
    repeat (6) @(negedge clk);
    btn = '0;
    repeat (8) @(negedge clk);
    model_press(mask, v);
  endtask

  task automatic read_disp(output int val, output int seen, output int bad);
    val = 0; seen = 0; bad = 0;
    for (int c = 0; c < 32; c++) begin
      int idx, nz, nib;
      @(negedge clk);
      idx = -1; nz = 0; nib = -1;
      for (int k = 0; k < NDIG; k++)
        if (!an[k]) begin nz++; idx = k; end
      for (int g = 0; g < 16; g++)
        if (sseg[6:0] == gly[g]) nib = g;
      if (nz != 1 || !sseg[7]) bad++;
      else begin
        seen |= (1 << idx);
        if (idx < W / 4) begin
          if (nib < 0) bad++;
          else val |= nib << (4 * idx);
        end else if (sseg[6:0] != 7'h7F) bad++;
      end
    end
  endtask

  task automatic check_state(input string tag, output int dval);
    int seen, bad, ev, eled;
    read_disp(dval, seen, bad);
    ev = (mview == 0) ? mx : (mview == 1) ? my : mz;
    eled = mop | (int'(meq) << 3) | (int'(mzero) << 4)
         | (int'(movf) << 5) | (mview << 6);
    chk({tag, " led"}, led, eled);
    chk({tag, " disp"}, dval, ev);
    chk({tag, " scan"}, seen, 32'hFF);
    chk({tag, " glyph"}, bad, 0);
  endtask

  int d;

  initial begin
    rst_n = 1'b0; sw = '0; btn = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst an", an, 8'hFE);
    chk("rst sseg", sseg, 8'hC0);
    chk("rst led", led, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // Three stable samples are one short of acceptance
    @(negedge clk);
    sw = 16'h1234; btn = 5'b00001;
    repeat (3) @(posedge clk);
    @(negedge clk) btn = '0;
    repeat (8) @(negedge clk);
    check_state("deb_short", d);
    chk("deb_short x", d, 0);

    // Long hold loads once; later switch changes are ignored
    @(negedge clk);
    btn = 5'b00001;
    repeat (6) @(posedge clk);
    @(negedge clk) sw = 16'h5678;
    repeat (6) @(negedge clk);
    btn = '0;
    repeat (8) @(negedge clk);
    model_press(1, 'h1234);
    check_state("deb_long", d);
    chk("deb_long x", d, 'h1234);

    press(1, 'h7FFF);
    press(4, 'h0001);
    // Result lands two edges after the centre pulse
    @(negedge clk);
    btn = 5'b10000;
    repeat (5) @(posedge clk);
    #1 chk("lat exec", led[7:6], 2'd1);
    @(posedge clk);
    #1 chk("lat show", led[7:6], 2'd2);
    @(negedge clk) btn = '0;
    repeat (8) @(negedge clk);
    model_press(16, 0);
    check_state("add_ovf", d);
    chk("add_ovf z", d, 'h8000);
    chk("add_ovf flag", led[5], 1'b1);

    press(2, 0);
    press(16, 0);
    check_state("sub", d);
    chk("sub z", d, 'h7FFE);
    press(1, 'h00AA);
    press(4, 'h00AA);
    press(16, 0);
    check_state("sub_eq", d);
    chk("sub_eq flags", led[4:3], 2'b11);

    press(8, 0);
    press(8, 0);
    chk("op wrap", led[2:0], 3'd7);
    press(1, 'h8000);
    press(4, 'h0013);
    press(16, 0);
    check_state("srl", d);
    chk("srl z", d, 'h1000);

    // Up and centre together: only the execute happens
    press(17, 'hBEEF);
    check_state("both", d);
    press(16, 0);
    check_state("both_rerun", d);
    chk("both x kept", d, 'h1000);

    press(2, 0);
    press(1, 'h00AB);
    press(4, 'h0000);
    press(16, 0);
    check_state("disp_ab", d);
    chk("disp_ab z", d, 'h00AB);

    // Reset in the EXEC cycle abandons the operation
    @(negedge clk);
    btn = 5'b10000;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; btn = '0;
    @(posedge clk);
    #1;
    chk("rst_exec led", led, 8'h00);
    chk("rst_exec an", an, 8'hFE);
    chk("rst_exec sseg", sseg, 8'hC0);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    check_state("post_rst", d);
    press(1, 'h1111);
    check_state("post_rst_up", d);

    for (int i = 0; i < 30; i++) begin
      int act, sel, v;
      act = $urandom_range(0, 4);
      sel = $urandom_range(0, 3);
      case (sel)
        0: v = $urandom_range(0, 65535);
        1: case ($urandom_range(0, 3))
             0: v = 'h7FFF;
             1: v = 'h8000;
             2: v = 'hFFFF;
             default: v = 'h0001;
           endcase
        2: v = mx;
        default: v = $urandom_range(0, 20);
      endcase
      press(1 << act, v);
      check_state($sformatf("rnd%0d", i), d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
